// File: rtl/line_buffer_reader_if.sv
// ---------------------------------------------------------------------------
// line_buffer_reader_if
//   Output word stream of the line buffer reader (valid/ready handshake).
//
//   Signals:
//     m_valid  word available at the stream head
//     m_ready  downstream accepts; a transfer happens when m_valid && m_ready
//     m_data   WIDTH-bit word
//     m_last   marks the final word of a line
//
//   Modports:
//     master   the reader (drives m_valid/m_data/m_last)
//     slave    the consumer (drives m_ready)
// ---------------------------------------------------------------------------
interface line_buffer_reader_if #(
    parameter int WIDTH = 27
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/line_buffer_reader.sv
// ---------------------------------------------------------------------------
// line_buffer_reader
//   Reads completed lines out of a two-bank line BRAM and streams them to a
//   valid/ready consumer. A writer announces every finished line with a
//   one-cycle line_wr_done pulse; up to two lines may be pending. Each line
//   is read from position 0..L-1 of the current bank (L = max(h_size, 2),
//   sampled when the line starts), then the bank toggles. BRAM words return
//   one cycle after rd_en and land in a 3-entry output FIFO, which bounds the
//   reads in flight so no word is ever dropped under back-pressure.
//
//   Ports:
//     clk           single clock, rising edge
//     rst           synchronous, active-high reset
//     h_size        line length in words
//     line_wr_done  pulse: one more full line is available
//     rd_en         BRAM read enable
//     rd_addr       BRAM read address {bank, position}
//     rd_data       BRAM read data, valid one cycle after rd_en
//     m             output stream (line_buffer_reader_if.master)
//     ovf           sticky "line_wr_done discarded while two lines pending"
//                   (present only when LINE_BUFFER_READER_OVF_EN is defined)
//
//   Build option: define LINE_BUFFER_READER_OVF_EN to add the ovf output.
// ---------------------------------------------------------------------------
module line_buffer_reader #(
    parameter int WIDTH       = 27,
    parameter int BRAM_SIZE_W = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BRAM_SIZE_W-1:0] h_size,
    input  logic                   line_wr_done,
    output logic                   rd_en,
    output logic [BRAM_SIZE_W:0]   rd_addr,
    input  logic [WIDTH-1:0]       rd_data,
`ifdef LINE_BUFFER_READER_OVF_EN
    output logic                   ovf,
`endif
    line_buffer_reader_if.master   m
);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             lines_avail, lines_nxt;
    logic                   bank;
    logic [BRAM_SIZE_W-1:0] pos;
    logic [BRAM_SIZE_W-1:0] len_q;
    logic [BRAM_SIZE_W-1:0] len_eff;
    logic                   load_len;

    logic                   room;
    logic                   issue;
    logic                   line_end;
    logic                   discard;
    logic                   wr_take;

    // One read may be in flight (BRAM latency is one cycle).
    logic                   inflight;
    logic                   inflight_last;

    // Output FIFO: entries are {last, data}.
    logic [WIDTH:0]         fifo_mem [3];
    logic [1:0]             wr_ptr, rd_ptr;
    logic [1:0]             fifo_cnt;
    logic                   push, pop;
    logic [WIDTH:0]         head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Lines shorter than two words are stretched to two.
    assign len_eff = (h_size < BRAM_SIZE_W'(2)) ? BRAM_SIZE_W'(2) : h_size;

    // A new read is allowed only if its word is guaranteed a FIFO slot.
    assign room     = ({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd3;
    assign issue    = (state == S_READ) && room && !rst;
    assign line_end = issue && (pos == len_q - BRAM_SIZE_W'(1));

    // A pulse is lost only when two lines are pending and none retires now.
    assign discard  = line_wr_done && (lines_avail == 2'd2) && !line_end;
    assign wr_take  = line_wr_done && !discard;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lines_nxt = lines_avail;
        case ({wr_take, line_end})
            2'b10:   lines_nxt = lines_avail + 2'd1;
            2'b01:   lines_nxt = lines_avail - 2'd1;
            default: lines_nxt = lines_avail;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_len  = 1'b0;
        case (state)
            S_IDLE: begin
                // Using the next count lets a pulse start reading the very
                // next cycle.
                if (lines_nxt != 2'd0) begin
                    state_nxt = S_READ;
                    load_len  = 1'b1;
                end
            end
            S_READ: begin
                if (line_end) begin
                    if (lines_nxt == 2'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        load_len  = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            lines_avail   <= 2'd0;
            bank          <= 1'b0;
            pos           <= '0;
            len_q         <= BRAM_SIZE_W'(2);
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            lines_avail   <= lines_nxt;
            inflight      <= issue;
            inflight_last <= line_end;
            if (load_len) begin
                len_q <= len_eff;
            end
            if (issue) begin
                if (line_end) begin
                    pos  <= '0;
                    bank <= ~bank;
                end else begin
                    pos  <= pos + BRAM_SIZE_W'(1);
                end
            end
        end
    end

    assign push = inflight && !rst;
    assign pop  = m.m_valid && m.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only ever observed
    // after it has been written, and the outputs are gated while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {inflight_last, rd_data};
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign m.m_valid = (fifo_cnt != 2'd0) && !rst;
    assign m.m_data  = m.m_valid ? head[WIDTH-1:0] : '0;
    assign m.m_last  = m.m_valid && head[WIDTH];

    assign rd_en   = issue;
    assign rd_addr = issue ? {bank, pos} : '0;

`ifdef LINE_BUFFER_READER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (discard) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_line_buffer_reader.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_reader
//   Directed bench for line_buffer_reader (WIDTH 27, BRAM_SIZE_W 11).
//   A BRAM model returns tb_word(addr) one cycle after each read, so every
//   expected word follows from the hand-written address sequence.
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_line_buffer_reader;

    localparam int WIDTH       = 27;
    localparam int BRAM_SIZE_W = 11;

    logic                   clk;
    logic                   rst;
    logic [BRAM_SIZE_W-1:0] h_size;
    logic                   line_wr_done;
    logic                   rd_en;
    logic [BRAM_SIZE_W:0]   rd_addr;
    logic [WIDTH-1:0]       rd_data = '0;
`ifdef LINE_BUFFER_READER_OVF_EN
    logic                   ovf;
`endif

    line_buffer_reader_if #(.WIDTH(WIDTH)) bus ();

    line_buffer_reader #(
        .WIDTH       (WIDTH),
        .BRAM_SIZE_W (BRAM_SIZE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .h_size       (h_size),
        .line_wr_done (line_wr_done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
`ifdef LINE_BUFFER_READER_OVF_EN
        .ovf          (ovf),
`endif
        .m            (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WIDTH-1:0] tb_word(input logic [11:0] a);
        return {15'h1357, a};
    endfunction

    // BRAM read port: one cycle latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= tb_word(rd_addr);
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observation logs filled on the falling edge.
    logic [27:0] words [$];
    int          wcyc  [$];
    logic [11:0] addrs [$];
    int first_rd, first_valid;
    int n_issue, n_xfer, max_out;
    int stall_cnt, stall_err;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_data;
    logic        prev_last;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if ((n_issue + int'(rd_en) - n_xfer) > max_out)
                max_out = n_issue + int'(rd_en) - n_xfer;
            if (prev_stall) begin
                stall_cnt++;
                if (!(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last))
                    stall_err++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (bus.m_valid && first_valid < 0) first_valid = cyc;
            if (bus.m_valid && bus.m_ready) begin
                words.push_back({bus.m_last, bus.m_data});
                wcyc.push_back(cyc);
                n_xfer++;
            end
            if (rd_en) begin
                addrs.push_back(rd_addr);
                n_issue++;
                if (first_rd < 0) first_rd = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        words.delete();
        wcyc.delete();
        addrs.delete();
        first_rd    = -1;
        first_valid = -1;
        n_issue     = 0;
        n_xfer      = 0;
        max_out     = 0;
        stall_cnt   = 0;
        stall_err   = 0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        line_wr_done = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        clear_logs();
    endtask

    task automatic pulse();
        line_wr_done = 1'b1;
        step(1);
        line_wr_done = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (words.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check({tag, " word count"}, words.size(), n);
    endtask

    // One line of len words starting at address base, logged from index idx0.
    task automatic check_line(input int idx0, input int len, input logic [11:0] base,
                              input string tag);
        logic [11:0] a;
        logic [31:0] obs_a, obs_w;
        for (int i = 0; i < len; i++) begin
            a     = base + 12'(i);
            obs_a = (idx0 + i < addrs.size()) ? {20'd0, addrs[idx0 + i]} : 32'hDEAD_BEEF;
            obs_w = (idx0 + i < words.size()) ? {4'd0, words[idx0 + i]} : 32'hDEAD_BEEF;
            check($sformatf("%s addr%0d", tag, i), obs_a, {20'd0, a});
            check($sformatf("%s word%0d", tag, i), obs_w, {4'd0, (i == len - 1), tb_word(a)});
        end
    endtask

    int n0;
    int k;

    initial begin
        rst          = 1'b1;
        line_wr_done = 1'b1;
        h_size       = 11'd4;
        bus.m_ready  = 1'b1;
        clear_logs();

        // Reset state, with line_wr_done and m_ready active underneath.
        step(3);
        @(negedge clk);
        check("reset rd_en",   {31'd0, rd_en},        32'd0);
        check("reset rd_addr", {20'd0, rd_addr},      32'd0);
        check("reset m_valid", {31'd0, bus.m_valid},  32'd0);
        check("reset m_data",  {5'd0, bus.m_data},    32'd0);
        check("reset m_last",  {31'd0, bus.m_last},   32'd0);
`ifdef LINE_BUFFER_READER_OVF_EN
        check("reset ovf",     {31'd0, ovf},          32'd0);
`endif
        @(posedge clk);
        #1;
        rst          = 1'b0;
        line_wr_done = 1'b0;
        step(6);
        check("post-reset reads", addrs.size(), 0);
        check("post-reset words", words.size(), 0);

        // Single line of 4 words: latency and address sequence.
        do_reset();
        h_size      = 11'd4;
        bus.m_ready = 1'b1;
        n0 = cyc;
        pulse();
        wait_words(4, 40, "L4");
        step(8);
        check("L4 total words", words.size(), 4);
        check("L4 first rd_en cycle", first_rd, n0 + 1);
        check("L4 first m_valid cycle", first_valid, n0 + 3);
        check_line(0, 4, 12'h000, "L4");
        check("L4 back-to-back", wcyc[3] - wcyc[0], 3);

        // Two lines of 3 words, no bubble between them, bank toggles.
        do_reset();
        h_size      = 11'd3;
        bus.m_ready = 1'b1;
        pulse();
        pulse();
        wait_words(6, 40, "2xL3");
        step(8);
        check("2xL3 total words", words.size(), 6);
        check_line(0, 3, 12'h000, "2xL3 a");
        check_line(3, 3, 12'h800, "2xL3 b");
        check("2xL3 back-to-back", wcyc[5] - wcyc[0], 5);

        // 8-word line with m_ready toggling every cycle.
        do_reset();
        h_size      = 11'd8;
        bus.m_ready = 1'b1;
        pulse();
        k = 0;
        while (words.size() < 8 && k < 100) begin
            bus.m_ready = ~bus.m_ready;
            step(1);
            k++;
        end
        check("L8 toggle word count", words.size(), 8);
        bus.m_ready = 1'b1;
        step(8);
        check("L8 toggle total words", words.size(), 8);
        check_line(0, 8, 12'h000, "L8");
        check("L8 stalls seen", {31'd0, stall_cnt > 0}, 32'd1);
        check("L8 stable while stalled", stall_err, 0);
        check("L8 outstanding <= 3", {31'd0, max_out <= 3}, 32'd1);

        // Three pulses while stalled: third is discarded.
        do_reset();
        h_size       = 11'd4;
        bus.m_ready  = 1'b0;
        line_wr_done = 1'b1;
        step(2);
`ifdef LINE_BUFFER_READER_OVF_EN
        check("ovf after two pulses", {31'd0, ovf}, 32'd0);
`endif
        step(1);
        line_wr_done = 1'b0;
`ifdef LINE_BUFFER_READER_OVF_EN
        check("ovf after third pulse", {31'd0, ovf}, 32'd1);
`endif
        step(8);
        check("stalled words", words.size(), 0);
        check("stalled reads capped", addrs.size(), 3);
        bus.m_ready = 1'b1;
        wait_words(8, 60, "ovf lines");
        step(20);
        check("ovf total words", words.size(), 8);
        check_line(0, 4, 12'h000, "ovf a");
        check_line(4, 4, 12'h800, "ovf b");
`ifdef LINE_BUFFER_READER_OVF_EN
        check("ovf sticky", {31'd0, ovf}, 32'd1);
`endif

        // Reset after 2 of 6 words aborts the line.
        do_reset();
        h_size      = 11'd6;
        bus.m_ready = 1'b1;
        pulse();
        k = 0;
        while (words.size() < 2 && k < 40) begin
            step(1);
            k++;
        end
        check("abort first words", words.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check("abort m_valid in reset", {31'd0, bus.m_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort m_valid after reset", {31'd0, bus.m_valid}, 32'd0);
        step(10);
        check("abort no further words", words.size(), 2);
        clear_logs();
        pulse();
        wait_words(6, 40, "restart");
        check_line(0, 6, 12'h000, "restart");

        // Short lengths stretch to 2; h_size change mid-line is ignored.
        do_reset();
        h_size      = 11'd0;
        bus.m_ready = 1'b1;
        pulse();
        wait_words(2, 30, "h0");
        step(5);
        check("h0 total words", words.size(), 2);
        check_line(0, 2, 12'h000, "h0");
        h_size = 11'd1;
        pulse();
        wait_words(4, 30, "h1");
        step(5);
        check("h1 total words", words.size(), 4);
        check_line(2, 2, 12'h800, "h1");
        h_size = 11'd4;
        pulse();
        h_size = 11'd2;
        wait_words(8, 30, "midline");
        step(8);
        check("midline total words", words.size(), 8);
        check_line(4, 4, 12'h000, "midline");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_buffer_reader.md
LINE_BUFFER_READER -- requirements
Module: line_buffer_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 27, data word width in bits.
REQ-002 SHALL have parameter BRAM_SIZE_W, default 11, address bits per line bank.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port h_size  input  BRAM_SIZE_W  line length in words.
REQ-006 SHALL have port line_wr_done  input  1  one-cycle pulse: writer committed one full line into the next bank.
REQ-007 SHALL have port rd_en  output  1  BRAM read-port enable.
REQ-008 SHALL have port rd_addr  output  BRAM_SIZE_W+1  read address {bank, position}.
REQ-009 SHALL have port rd_data  input  WIDTH  BRAM read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port m_valid  output  1  output word valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts; transfer when m_valid && m_ready.
REQ-012 SHALL have port m_data  output  WIDTH  output word.
REQ-013 SHALL have port m_last  output  1  high with the last word of a line.

Function
REQ-014 SHALL keep lines_avail (0..2): +1 on line_wr_done, -1 when the last read of a line is issued; both in one cycle leaves it unchanged.
REQ-015 SHALL implement FSM IDLE -> READ when lines_avail > 0; READ -> IDLE after issuing the last address if lines_avail becomes 0, else stay in READ for the next line with no bubble.
REQ-016 SHALL latch effective length L = max(h_size, 2) on entering a line; h_size changes mid-line SHALL NOT affect that line.
REQ-017 SHALL issue addresses position 0..L-1 in the current bank, then toggle bank (0 first after reset) and reset position to 0.
REQ-018 SHALL assert rd_en only in READ and only when (output FIFO occupancy + in-flight reads) < 3.
REQ-019 SHALL capture rd_data one cycle after each rd_en into a 3-entry output FIFO tagged with its last flag; no word SHALL ever be dropped or duplicated.
REQ-020 SHALL drive m_valid/m_data/m_last from the FIFO head; once m_valid is high, m_data and m_last SHALL hold until the transfer.
REQ-021 SHALL have latency 3 cycles: line_wr_done in cycle N with lines_avail 0 -> rd_en in N+1 -> m_valid in N+3.
REQ-022 SHALL sustain 1 word/cycle while m_ready is held high.
REQ-023 SHALL saturate lines_avail at 2 when line_wr_done arrives while full; the pulse is discarded.
REQ-024 SHALL keep position arithmetic in BRAM_SIZE_W bits; L = 2^BRAM_SIZE_W is unreachable (h_size 0 maps to 2).

Reset
REQ-025 SHALL on rst: state IDLE, lines_avail 0, bank 0, position 0, FIFO empty, in-flight reads discarded.
REQ-026 SHALL drive during and after reset: rd_en 0, rd_addr 0, m_valid 0, m_data 0, m_last 0.
REQ-027 SHALL give rst priority over line_wr_done and m_ready in the same cycle; reset mid-line aborts the line with no further m_valid.

Configuration
REQ-028 SHALL, with LINE_BUFFER_READER_OVF_EN defined, add output ovf (1 bit): sticky high from the cycle after a discarded line_wr_done, cleared only by rst.
REQ-029 SHALL, without LINE_BUFFER_READER_OVF_EN, omit port ovf; all other behaviour is identical.

Verification
REQ-030 SHALL cover: h_size=4, one line_wr_done, m_ready=1 -> m_valid first in cycle N+3, 4 consecutive words from addresses 0..3 (bank 0), m_last on 4th.
REQ-031 SHALL cover: two line_wr_done pulses, h_size=3, m_ready=1 -> 6 consecutive words, addresses 0,1,2 then 2048,2049,2050, m_last on words 3 and 6.
REQ-032 SHALL cover: h_size=8, m_ready toggling 1/0 each cycle -> exactly 8 words in order, data stable while stalled, at most 3 reads outstanding.
REQ-033 SHALL cover: three line_wr_done pulses with m_ready=0 -> lines_avail stays 2, only 2 lines emitted after m_ready=1, ovf=1 when macro defined.
REQ-034 SHALL cover: rst asserted after 2 of 6 words -> m_valid 0 next cycle, next line restarts at rd_addr 0.
REQ-035 SHALL cover: h_size=0 and h_size=1 -> each line emits exactly 2 words with m_last on the 2nd.
